// File: rtl/mac_frame_sequencer.sv
// ============================================================================
// Module  : mac_frame_sequencer
// Brief   : Drives one N-term multiply-accumulate frame through the MAC array
//           and returns the N-lane result vector over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_frame_sequencer #(
    parameter int N       = 5,
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = 2*WIDTH+N-1,
    parameter int AW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [N*WIDTH-1:0]   a_rd_data,
    input  logic [WIDTH-1:0]     b_rd_data,
    output logic                 mac_sof,
    output logic [N*WIDTH-1:0]   mac_A,
    output logic [WIDTH-1:0]     mac_B,
    input  logic [N*M_WIDTH-1:0] mac_C,
    input  logic [N-1:0]         mac_valid,
    output logic [N*M_WIDTH-1:0] res,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam int            CW          = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(N - 1);
    localparam logic [CW-1:0] C_CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N-1:0]           mask_q, mask_d;
    logic                   err_q, err_d;
    logic                   to_done_q, to_done_d;
    logic [N*M_WIDTH-1:0]   res_q, res_d;
    logic                   rd_vld_q;
    logic                   sof_pend_q;
    logic                   mac_sof_q;
    logic [N*WIDTH-1:0]     mac_a_q;
    logic [WIDTH-1:0]       mac_b_q;

    logic                   w_capture_en;
    logic [N-1:0]           w_hit;
    logic [N-1:0]           w_mask_next;

    assign w_capture_en = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign w_hit        = mac_valid & ~mask_q & {N{w_capture_en}};
    assign w_mask_next  = mask_q | w_hit;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        mask_d    = w_mask_next;
        err_d     = err_q;
        to_done_d = 1'b0;
        res_d     = res_q;

        for (int i = 0; i < N; i++) begin
            if (w_hit[i]) begin
                res_d[i*M_WIDTH +: M_WIDTH] = mac_C[i*M_WIDTH +: M_WIDTH];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    addr_d  = '0;
                    mask_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (addr_q == C_LAST_ADDR) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_WAIT: begin
                // Completion in the final counted cycle still wins over timeout.
                if (&w_mask_next) begin
                    state_d = S_OUT;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    to_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
            to_done_q  <= 1'b0;
            res_q      <= '0;
            rd_vld_q   <= 1'b0;
            sof_pend_q <= 1'b0;
            mac_sof_q  <= 1'b0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            to_done_q  <= to_done_d;
            res_q      <= res_d;
            // RAM data lags the read strobe by one cycle; track it to load the operands.
            rd_vld_q   <= (state_q == S_ISSUE);
            sof_pend_q <= (state_q == S_ISSUE) && (addr_q == '0);
            mac_sof_q  <= sof_pend_q;
            if (rd_vld_q) begin
                mac_a_q <= a_rd_data;
                mac_b_q <= b_rd_data;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rd_en     = (state_q == S_ISSUE);
    assign rd_addr   = addr_q;
    assign mac_sof   = mac_sof_q;
    assign mac_A     = mac_a_q;
    assign mac_B     = mac_b_q;
    assign res       = res_q;
    assign res_valid = (state_q == S_OUT);
    assign err       = err_q;
    // Handoff done coincides with the accepting cycle; timeout done is registered.
    assign done      = to_done_q || ((state_q == S_OUT) && res_ready);

endmodule

`default_nettype wire

// File: tb/tb_mac_frame_sequencer.sv
// ============================================================================
// Module  : tb_mac_frame_sequencer
// Brief   : Directed self-checking bench with RAM and MAC-array models.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_frame_sequencer;

    localparam int N    = 5;
    localparam int W    = 16;
    localparam int MW   = 2*W+N-1;
    localparam int AW   = 3;
    localparam int TO   = 64;
    localparam int PIPE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, err, rd_en, mac_sof, res_valid;
    logic            res_ready;
    logic [AW-1:0]   rd_addr;
    logic [N*W-1:0]  a_rd_data = '0;
    logic [W-1:0]    b_rd_data = '0;
    logic [N*W-1:0]  mac_A;
    logic [W-1:0]    mac_B;
    logic [N*MW-1:0] mac_C;
    logic [N-1:0]    mac_valid;
    logic [N*MW-1:0] res;

    mac_frame_sequencer #(.N(N), .WIDTH(W), .M_WIDTH(MW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .mac_sof(mac_sof), .mac_A(mac_A), .mac_B(mac_B), .mac_C(mac_C),
        .mac_valid(mac_valid), .res(res), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // RAM models
    logic [N*W-1:0] amem [N];
    logic [W-1:0]   bmem [N];
    always @(posedge clk) begin
        if (rd_en && (int'(rd_addr) < N)) begin
            a_rd_data <= amem[rd_addr];
            b_rd_data <= bmem[rd_addr];
        end
    end

    // Behavioural MAC array; mode 0 uses it, other modes use scripted stub values
    int              mode = 0;
    logic [N-1:0]    s_valid = '0;
    logic [N*MW-1:0] s_C = '0;
    logic [MW-1:0]   acc [N];
    int              term = 0;
    logic [PIPE-1:0] pv = '0;
    logic [N*MW-1:0] m_C;

    always @(posedge clk) begin
        if (rst) begin
            term <= 0;
            pv   <= '0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else begin
            pv <= {pv[PIPE-2:0], (!mac_sof && term == N-1)};
            if (mac_sof) begin
                for (int i = 0; i < N; i++) acc[i] <= MW'(mac_A[i*W +: W]) * MW'(mac_B);
                term <= 1;
            end else if (term > 0 && term < N) begin
                for (int i = 0; i < N; i++) acc[i] <= acc[i] + MW'(mac_A[i*W +: W]) * MW'(mac_B);
                term <= term + 1;
            end
        end
    end

    always_comb begin
        m_C = '0;
        for (int i = 0; i < N; i++) m_C[i*MW +: MW] = acc[i];
    end

    assign mac_valid = (mode == 0) ? {N{pv[PIPE-1]}} : s_valid;
    assign mac_C     = (mode == 0) ? m_C : s_C;

    // Event monitors
    int n_rd = 0, n_sof = 0, n_done = 0, n_rv = 0;
    always @(posedge clk) begin
        if (rd_en)     n_rd   <= n_rd + 1;
        if (mac_sof)   n_sof  <= n_sof + 1;
        if (done)      n_done <= n_done + 1;
        if (res_valid) n_rv   <= n_rv + 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // kind 0: A=1 all lanes, B=k+1; kind 1: A=lane+1, B=k+1; kind 2: A=B=FFFF
    task automatic load_pat(input int kind);
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                amem[k][i*W +: W] = (kind == 0) ? W'(1) : (kind == 1) ? W'(i + 1) : {W{1'b1}};
            end
            bmem[k] = (kind == 2) ? {W{1'b1}} : W'(k + 1);
        end
    endtask

    function automatic logic [N*MW-1:0] exp_pat(input int kind);
        logic [N*MW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*MW +: MW] = (kind == 0) ? MW'(15) :
                            (kind == 1) ? MW'(15 * (i + 1)) : 36'd21474181125;
        end
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (res_valid) begin ok = 1'b1; break; end
        end
        check_eq(tag, ok, 1'b1);
    endtask

    task automatic handoff(input string tag, input logic [N*MW-1:0] exp);
        @(negedge clk); res_ready = 1'b1; #1;
        check_eq({tag, "_done"}, done, 1'b1);
        @(posedge clk); #1;
        check_eq({tag, "_after"}, {res_valid, busy, done}, 3'b000);
        check_eq({tag, "_kept"}, res, exp);
        @(negedge clk); res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s_rd, s_sof, s_done, s_rv, cyc;
        logic [N*MW-1:0] e;
        logic [N*MW-1:0] stub;
        int lanes [6];
        int vals  [6];

        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_ctrl", {busy, done, err, rd_en, mac_sof, res_valid}, 6'b0);
        check_eq("rst_data", {rd_addr, mac_A, mac_B}, '0);
        check_eq("rst_res", res, '0);
        @(negedge clk); rst = 1'b0;

        // 1: basic frame
        load_pat(0);
        s_rd = n_rd; s_sof = n_sof;
        pulse_start();
        wait_res("t1_wait");
        check_eq("t1_res", res, exp_pat(0));
        check_eq("t1_err", err, 1'b0);
        check_eq("t1_rdcnt", n_rd - s_rd, N);
        check_eq("t1_sof", n_sof - s_sof, 1);
        handoff("t1", exp_pat(0));

        // 2: consumer stalls for 10 cycles
        load_pat(1);
        pulse_start();
        wait_res("t2_wait");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t2_hold", {res_valid, done, res}, {1'b1, 1'b0, exp_pat(1)});
        end
        handoff("t2", exp_pat(1));

        // 3: start pulses while busy and at handoff are ignored; max operands
        load_pat(2);
        s_rd = n_rd; s_done = n_done;
        pulse_start();
        pulse_start();
        cyc = 0;
        while (rd_en && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_eq("t3_inwait", {busy, rd_en}, 2'b10);
        pulse_start();
        wait_res("t3_wait");
        check_eq("t3_res", res, exp_pat(2));
        @(negedge clk); res_ready = 1'b1; start = 1'b1;
        @(negedge clk); res_ready = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check_eq("t3_noqueue", busy, 1'b0);
        check_eq("t3_rdcnt", n_rd - s_rd, N);
        check_eq("t3_donecnt", n_done - s_done, 1);

        // 4: array never responds -> timeout
        mode = 1; s_valid = '0;
        s_rv = n_rv;
        pulse_start();
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done) begin cyc = c; break; end
        end
        check_eq("t4_latency", cyc, N + TO);
        check_eq("t4_err", {done, err, busy}, 3'b110);
        @(posedge clk); #1;
        check_eq("t4_pulse", {done, err}, 2'b01);
        check_eq("t4_novalid", n_rv - s_rv, 0);
        mode = 0;
        load_pat(0);
        pulse_start(); #1;
        check_eq("t4_errclr", err, 1'b0);
        wait_res("t4_wait");
        check_eq("t4_res", res, exp_pat(0));
        handoff("t4", exp_pat(0));

        // 5: lanes complete on separate cycles, lane 2 repeats
        mode = 2;
        lanes = '{0, 2, 4, 2, 1, 3};
        vals  = '{100, 102, 104, 999, 101, 103};
        pulse_start();
        for (int j = 0; j < 6; j++) begin
            stub = '0;
            for (int i = 0; i < N; i++) stub[i*MW +: MW] = MW'(36'h0BAD);
            stub[lanes[j]*MW +: MW] = MW'(vals[j]);
            @(negedge clk); s_valid = N'(1) << lanes[j]; s_C = stub;
            @(posedge clk); #1;
            if (j == 4) check_eq("t5_early", res_valid, 1'b0);
            if (j == 5) check_eq("t5_out", res_valid, 1'b1);
        end
        @(negedge clk); s_valid = '0;
        e = '0;
        for (int i = 0; i < N; i++) e[i*MW +: MW] = MW'(100 + i);
        check_eq("t5_res", res, e);
        handoff("t5", e);

        // 6: reset mid-ISSUE, then a clean frame
        mode = 0;
        load_pat(1);
        pulse_start();
        cyc = 0;
        while (!(rd_en && rd_addr == 3'd2) && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_eq("t6_reach", {rd_en, rd_addr}, {1'b1, 3'd2});
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_ctrl", {busy, done, err, rd_en, mac_sof, res_valid}, 6'b0);
        check_eq("t6_data", {rd_addr, mac_A, mac_B, res}, '0);
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk);
        pulse_start();
        wait_res("t6_wait");
        check_eq("t6_res", res, exp_pat(1));
        handoff("t6", exp_pat(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
